// File: rtl/lu_seq_arbiter.sv
// Two-requester arbiter feeding a bit-serial logic unit (NOR/OR/XOR/XNOR, LSB first).
// Define LU_SEQ_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (requester 0).
module lu_seq_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [3:0]         req_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_y,
  output logic               rsp_id,
  output logic               busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  logic             id_q, id_d;
  logic             gnt_id;
  logic             load;

  function automatic logic op_bit(input logic [1:0] sel, input logic a, input logic b);
    case (sel)
      2'b00:   op_bit = ~(a | b);
      2'b01:   op_bit = a | b;
      2'b10:   op_bit = a ^ b;
      default: op_bit = ~(a ^ b);
    endcase
  endfunction

`ifdef LU_SEQ_ARBITER_RR_EN
  // last_q holds the most recently granted requester; the other one wins a contest.
  logic last_q, last_d;

  always_comb begin
    gnt_id = req_valid[1] & (~req_valid[0] | ~last_q);
    last_d = load ? gnt_id : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    gnt_id = req_valid[1] & ~req_valid[0];
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    rsp_y_d   = rsp_y_q;
    rsp_id_d  = rsp_id_q;
    req_ready = 2'b00;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid && !rst) begin
          req_ready = gnt_id ? 2'b10 : 2'b01;
          load      = 1'b1;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        y_d[cnt_q] = op_bit(sel_q, a_q[cnt_q], b_q[cnt_q]);
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Result is published only now, so rsp_y stays put while the next operation runs.
          cnt_d    = '0;
          rsp_y_d  = y_d;
          rsp_id_d = id_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sel_d = sel_q;
    id_d  = id_q;
    if (load) begin
      a_d   = gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
      b_d   = gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
      sel_d = gnt_id ? req_sel[3:2] : req_sel[1:0];
      id_d  = gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      y_q      <= '0;
      rsp_y_q  <= '0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      rsp_y_q  <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  // Latched operands need no reset: they are only read in RUN, after a load.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sel_q <= sel_d;
    id_q  <= id_d;
  end

  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_lu_seq_arbiter.sv
// Directed bench for lu_seq_arbiter (WIDTH=8): vector table plus stall, reset-abort and contest sequences.
module tb_lu_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic        rsp_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  lu_seq_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic [7:0] y;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic start_req(input bit id, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] sel, input string nm);
    req_a   = id ? {a, 8'h00} : {8'h00, a};
    req_b   = id ? {b, 8'h00} : {8'h00, b};
    req_sel = id ? {sel, 2'b00} : {2'b00, sel};
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    chk({nm, "_ready"}, req_ready, id ? 2'b10 : 2'b01);
    cyc();
    req_valid = 2'b00;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      cyc();
      lat++;
    end
  endtask

  int lat;
  int seen;
  int last_acc, acc_cnt;
  logic [1:0] exp_g[3];

  initial begin
    vecs[0] = '{1'b0, 8'hF0, 8'hCC, 2'b00, 8'h03};
    vecs[1] = '{1'b1, 8'hF0, 8'hCC, 2'b01, 8'hFC};
    vecs[2] = '{1'b1, 8'hF0, 8'hCC, 2'b10, 8'h3C};
    vecs[3] = '{1'b1, 8'hF0, 8'hCC, 2'b11, 8'hC3};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 2'b10, 8'hFF};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 2'b00, 8'hFF};
    vecs[6] = '{1'b1, 8'hA5, 8'h5A, 2'b10, 8'hFF};
    vecs[7] = '{1'b0, 8'hA5, 8'h0F, 2'b11, 8'h55};
`ifdef LU_SEQ_ARBITER_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`endif

    // Reset with both requests asserted: nothing may be granted.
    rst = 1'b1; req_valid = 2'b11; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
    cyc(); cyc();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_y", rsp_y, 8'h00);
    chk("rst_rsp_id", rsp_id, 1'b0);
    req_valid = 2'b00;
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 8; i++) begin
      start_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel, $sformatf("v%0d", i));
      chk($sformatf("v%0d_run_ready", i), req_ready, 2'b00);
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), lat, 8);
      chk($sformatf("v%0d_y", i), rsp_y, vecs[i].y);
      chk($sformatf("v%0d_id", i), rsp_id, vecs[i].id);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_idle_busy", i), {busy, rsp_valid}, 2'b00);
      chk($sformatf("v%0d_hold_y", i), rsp_y, vecs[i].y);
    end

    // Back-pressure: response held for 5 cycles with requests pending.
    start_req(1'b0, 8'hF0, 8'hCC, 2'b00, "stall");
    wait_rsp(lat);
    chk("stall_latency", lat, 8);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_state", k), {rsp_valid, busy, req_ready, rsp_id}, {1'b1, 1'b1, 2'b00, 1'b0});
      chk($sformatf("stall%0d_y", k), rsp_y, 8'h03);
      cyc();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("stall_release", {busy, rsp_valid}, 2'b00);

    // Reset while bit 3 is being computed.
    start_req(1'b1, 8'hFF, 8'h00, 2'b10, "abort");
    cyc(); cyc(); cyc();
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_now", {busy, rsp_valid, rsp_id}, 3'b000);
    chk("abort_y", rsp_y, 8'h00);
    cyc();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    start_req(1'b1, 8'hF0, 8'hCC, 2'b10, "post");
    wait_rsp(lat);
    chk("post_latency", lat, 8);
    chk("post_y", rsp_y, 8'h3C);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // Contest: both requesters held valid across three operations after reset.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_a = 16'h0F_F0; req_b = 16'h00_00; req_sel = 4'b01_01;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    acc_cnt = 0;
    last_acc = 0;
    for (int g = 0; g < 3; g++) begin
      seen = 0;
      #1;
      while (req_ready == 2'b00 && seen < 40) begin
        cyc();
        #1;
        seen++;
      end
      chk($sformatf("grant%0d", g), req_ready, exp_g[g]);
      if (g > 0) chk($sformatf("grant%0d_spacing", g), acc_cnt - last_acc, 10);
      last_acc = acc_cnt;
      cyc();
      acc_cnt++;
      wait_rsp(lat);
      acc_cnt += lat;
      chk($sformatf("grant%0d_id", g), rsp_id, (exp_g[g] == 2'b10) ? 1'b1 : 1'b0);
      chk($sformatf("grant%0d_y", g), rsp_y, (exp_g[g] == 2'b10) ? 8'h0F : 8'hF0);
      cyc();
      acc_cnt++;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lu_seq_arbiter.md
LU_SEQ_ARBITER -- requirements
Module: lu_seq_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 Port rst SHALL be input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port req_valid SHALL be input, 2 bits: bit n set means requester n offers an operation.
REQ-005 Port req_ready SHALL be output, 2 bits: bit n set means requester n's operation is accepted this cycle.
REQ-006 Port req_a SHALL be input, 2*WIDTH bits: operand A; bits [WIDTH-1:0] belong to requester 0, the upper half to requester 1.
REQ-007 Port req_b SHALL be input, 2*WIDTH bits: operand B, packed as req_a.
REQ-008 Port req_sel SHALL be input, 4 bits: operation select; [1:0] belongs to requester 0, [3:2] to requester 1.
REQ-009 Port rsp_valid SHALL be output, 1 bit: a result is presented.
REQ-010 Port rsp_ready SHALL be input, 1 bit: the consumer accepts the result.
REQ-011 Port rsp_y SHALL be output, WIDTH bits: the result word.
REQ-012 Port rsp_id SHALL be output, 1 bit: the index of the requester that owns rsp_y.
REQ-013 Port busy SHALL be output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, RUN and RESP.
REQ-015 In IDLE, when any req_valid bit is high, the block SHALL drive exactly one req_ready bit high, for the granted requester, in the same cycle; no requester is granted when no req_valid bit is high.
REQ-016 On an edge with req_valid[g] and req_ready[g] both high, the block SHALL latch the operands, select and id g, clear the bit counter, and enter RUN.
REQ-017 req_ready SHALL be 0 in RUN and RESP.
REQ-018 A requester that drops req_valid before its handshake SHALL NOT be granted.
REQ-019 In RUN, each cycle SHALL compute one result bit i (LSB first) from a[i] and b[i], using select 00=NOR, 01=OR, 10=XOR, 11=XNOR, and store it into result bit i.
REQ-020 After bit WIDTH-1 is written, the block SHALL enter RESP; rsp_valid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_y and rsp_id SHALL hold stable until an edge with rsp_ready high.
REQ-022 On that rsp_ready edge the block SHALL return to IDLE; the earliest next grant SHALL occur the following cycle, giving a minimum of WIDTH+2 cycles per operation.
REQ-023 rsp_valid SHALL be 0 outside RESP; rsp_y and rsp_id SHALL retain their last value after the response handshake.
REQ-024 Requests SHALL be served one at a time, with no overlap and no loss of a latched operation.

Reset
REQ-025 While rst is high, state SHALL be IDLE, and req_ready, rsp_valid, rsp_y, rsp_id, busy, the bit counter and the result register SHALL all be 0.
REQ-026 While rst is high, the arbitration pointer SHALL be set so that requester 0 wins the first contest.
REQ-027 Reset asserted mid-RUN or mid-RESP SHALL abort the operation immediately, with no response issued after release.

Configuration
REQ-028 With macro LU_SEQ_ARBITER_RR_EN defined, arbitration SHALL be round-robin: on contest, the requester not granted last wins.
REQ-029 The round-robin pointer SHALL update only on a request handshake.
REQ-030 Without LU_SEQ_ARBITER_RR_EN, arbitration SHALL be fixed priority, with requester 0 always winning a contest; no pointer register exists.

Verification (WIDTH=8)
REQ-031 Bench: req0 a=0xF0 b=0xCC sel=00 -> rsp_y=0x03, rsp_id=0, rsp_valid high 8 cycles after the accept edge.
REQ-032 Bench: same operands with sel=01/10/11 on requester 1 -> rsp_y=0xFC/0x3C/0xC3, rsp_id=1.
REQ-033 Bench: both req_valid held high for three operations after reset -> with RR_EN, grant order 0,1,0; without RR_EN, grant order 0,0,0.
REQ-034 Bench: rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_y and rsp_id stable, req_ready=00, busy=1; release -> IDLE on the next edge.
REQ-035 Bench: rst pulsed during RUN at bit 3 -> busy, rsp_valid and rsp_y go to 0 immediately; no rsp_valid after release until a new request.
REQ-036 Bench: a=0xFF b=0x00 sel=10, then immediately a=0x00 b=0x00 sel=00 -> 0xFF then 0xFF; the bit counter wraps cleanly between operations.
